// File: rtl/shift_add_mul_pkg.sv
// rtl/shift_add_mul_pkg.sv - shared FSM state encoding for the shift-add multiplier
package shift_add_mul_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_add_mul_ctrl.sv
// rtl/shift_add_mul_ctrl.sv - sequencing FSM: emits load/step/finish strobes, busy and done
module shift_add_mul_ctrl
    import shift_add_mul_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic b_zero,
    output logic busy,
    output logic done,
    output logic load,
    output logic step,
    output logic finish
);

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // start is deliberately not looked at here or in DONE
                if (b_zero) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule

// File: rtl/shift_add_mul.sv
// rtl/shift_add_mul.sv - sequential shift-add multiplier; optional signed mode under SEQ_MUL_SIGNED_EN
module shift_add_mul
    import shift_add_mul_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
`ifdef SEQ_MUL_SIGNED_EN
    input  logic               signed_op,
`endif
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    logic [2*WIDTH-1:0] a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [2*WIDTH-1:0] acc;
    logic               neg_q;

    logic               load;
    logic               step;
    logic               finish;
    logic               b_zero;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               neg_d;

`ifdef SEQ_MUL_SIGNED_EN
    // The most-negative value negates onto itself, which read unsigned is its magnitude.
    always_comb begin
        a_mag = (signed_op && a_in[WIDTH-1]) ? ('0 - a_in) : a_in;
        b_mag = (signed_op && b_in[WIDTH-1]) ? ('0 - b_in) : b_in;
        neg_d = signed_op && (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
    end
`else
    always_comb begin
        a_mag = a_in;
        b_mag = b_in;
        neg_d = 1'b0;
    end
`endif

    assign b_zero = (b_reg == '0);

    shift_add_mul_ctrl u_ctrl (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .b_zero (b_zero),
        .busy   (busy),
        .done   (done),
        .load   (load),
        .step   (step),
        .finish (finish)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            neg_q   <= 1'b0;
            product <= '0;
        end else begin
            if (load) begin
                a_reg <= {{WIDTH{1'b0}}, a_mag};
                b_reg <= b_mag;
                acc   <= '0;
                neg_q <= neg_d;
            end else if (step) begin
                acc   <= acc + (b_reg[0] ? a_reg : '0);
                a_reg <= a_reg << 1;
                b_reg <= b_reg >> 1;
            end
            if (finish) begin
                product <= neg_q ? ('0 - acc) : acc;
            end
        end
    end

endmodule
